// File: rtl/fp_custom_pkg.sv
// Shared definitions for the custom floating-point datapath.
// Word format: {sign, exponent[ExpWidth], mantissa[ManWidth]}, bias
// 2^(ExpWidth-1)-1, implied leading one, exponent field 0 encodes zero.
// Helper functions size ports and constants; FP_LATENCY is the fixed
// latency of fp_custom_from_fixed, for wrappers and benches.
package fp_custom_pkg;

  localparam int FP_LATENCY = 4;

  function automatic int fp_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fp_lod.sv
// Combinational leading-one detector.
// Ports:
//   vec_i  [Width]          input vector
//   idx_o  [clog2(Width)]   index of the highest set bit (0 when vec_i == 0)
//   zero_o                  vec_i is all zeros
module fp_lod
  import fp_custom_pkg::*;
#(
  parameter int Width = 16,
  parameter int IdxW  = fp_clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             zero_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/fp_custom_from_fixed.sv
// Pipelined signed fixed-point to custom floating-point converter.
// Fixed latency FP_LATENCY (4) cycles, one sample per cycle, no backpressure.
// Ports:
//   Clk_i          clock, rising edge
//   Rst_i          synchronous active-high reset
//   Data_i         [IntWidth] signed sample, value = Data_i * 2^-FracWidth
//   Nd_i           Data_i is a new sample this edge
//   Result_o       [1+ExpWidth+ManWidth] {sign, exp, man}
//   ResultValid_o  Result_o carries a new conversion this cycle
//   Overflow_o     result saturated (meaningful with ResultValid_o)
module fp_custom_from_fixed
  import fp_custom_pkg::*;
#(
  parameter int ManWidth  = 16,
  parameter int ExpWidth  = 6,
  parameter int IntWidth  = 16,
  parameter int FracWidth = 0
) (
  input  logic                                    Clk_i,
  input  logic                                    Rst_i,
  input  logic signed [IntWidth-1:0]              Data_i,
  input  logic                                    Nd_i,
  output logic [fp_word_w(ExpWidth, ManWidth)-1:0] Result_o,
  output logic                                    ResultValid_o,
  output logic                                    Overflow_o
);

  localparam int WORD_W  = fp_word_w(ExpWidth, ManWidth);
  localparam int BIAS    = fp_bias(ExpWidth);
  localparam int IDX_W   = fp_clog2(IntWidth);
  localparam int E_CLOG  = fp_clog2(IntWidth + FracWidth);
  // Wide enough to hold Bias + p - FracWidth without wrapping either way.
  localparam int EW_E    = ((ExpWidth > E_CLOG) ? ExpWidth : E_CLOG) + 2;
  localparam int EXP_MAX = (1 << ExpWidth) - 1;

  // Valid shift register (control, reset)
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

  // S1 data
  logic                      sign_p1_q;
  logic [IntWidth-1:0]       mag_p1_q, mag_p1_d;
  // S2 data
  logic                      sign_p2_q, zero_p2_q, lod_zero;
  logic [IntWidth-1:0]       mag_p2_q;
  logic [IDX_W-1:0]          idx_p2_q, lod_idx;
  // S3 data
  logic                      sign_p3_q, zero_p3_q;
  logic [ManWidth-1:0]       man_p3_q, man_p3_d;
  logic signed [EW_E-1:0]    e_p3_q, e_p3_d;
  // S4 data
  logic [WORD_W-1:0]         word_p4_q, word_p4_d;
  logic                      ovf_p4_q, ovf_p4_d;
  logic signed [31:0]        e_int;
  // Output registers
  logic [WORD_W-1:0]         result_q;
  logic                      result_vld_q, ovf_q;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      vld_p4_q     <= 1'b0;
      result_vld_q <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      vld_p1_q     <= Nd_i;
      vld_p2_q     <= vld_p1_q;
      vld_p3_q     <= vld_p2_q;
      vld_p4_q     <= vld_p3_q;
      result_vld_q <= vld_p4_q;
      if (vld_p4_q) begin
        result_q <= word_p4_q;
        ovf_q    <= ovf_p4_q;
      end
    end
  end

  // ---- S1: sign / magnitude ----
  // Negating the most negative value wraps to 2^(IntWidth-1), which is the
  // correct unsigned magnitude.
  assign mag_p1_d = Data_i[IntWidth-1] ? $unsigned(-Data_i) : $unsigned(Data_i);

  always_ff @(posedge Clk_i) begin
    if (Nd_i) begin
      sign_p1_q <= Data_i[IntWidth-1];
      mag_p1_q  <= mag_p1_d;
    end
  end

  // ---- S2: leading-one detect ----
  fp_lod #(
    .Width (IntWidth)
  ) u_lod (
    .vec_i  (mag_p1_q),
    .idx_o  (lod_idx),
    .zero_o (lod_zero)
  );

  always_ff @(posedge Clk_i) begin
    if (vld_p1_q) begin
      sign_p2_q <= sign_p1_q;
      mag_p2_q  <= mag_p1_q;
      idx_p2_q  <= lod_idx;
      zero_p2_q <= lod_zero;
    end
  end

  // ---- S3: normalize and exponent ----
  // Appending ManWidth zeros and shifting right by p leaves exactly the
  // ManWidth bits below the leading one in the low field: zero-padded when
  // p < ManWidth, truncated (no rounding) otherwise.
  assign man_p3_d = ManWidth'({mag_p2_q, {ManWidth{1'b0}}} >> idx_p2_q);
  assign e_p3_d   = EW_E'(BIAS + int'(idx_p2_q) - FracWidth);

  always_ff @(posedge Clk_i) begin
    if (vld_p2_q) begin
      sign_p3_q <= sign_p2_q;
      zero_p3_q <= zero_p2_q;
      man_p3_q  <= man_p3_d;
      e_p3_q    <= e_p3_d;
    end
  end

  // ---- S4: zero / underflow / saturation select ----
  assign e_int = 32'(e_p3_q);

  always_comb begin
    word_p4_d = '0;
    ovf_p4_d  = 1'b0;
    if (zero_p3_q || (e_int <= 0)) begin
      word_p4_d = '0;
    end else if (e_int > EXP_MAX) begin
      word_p4_d = {sign_p3_q, {(ExpWidth + ManWidth){1'b1}}};
      ovf_p4_d  = 1'b1;
    end else begin
      word_p4_d = {sign_p3_q, e_p3_q[ExpWidth-1:0], man_p3_q};
    end
  end

  always_ff @(posedge Clk_i) begin
    if (vld_p3_q) begin
      word_p4_q <= word_p4_d;
      ovf_p4_q  <= ovf_p4_d;
    end
  end

  // ---- Output ----
  assign Result_o      = result_q;
  assign ResultValid_o = result_vld_q;
  assign Overflow_o    = ovf_q;

endmodule

// File: tb/tb_fp_custom_from_fixed.sv
// Bench for fp_custom_from_fixed: three instances (defaults, ExpWidth=4,
// FracWidth=40) share one stimulus stream; a queue of accepted samples with
// their due cycle is checked every cycle against a plain-arithmetic model.
module tb_fp_custom_from_fixed;
  import fp_custom_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               nd;
  logic signed [15:0] data;

  logic [22:0] res_def;  logic vld_def;  logic ovf_def;
  logic [20:0] res_e4;   logic vld_e4;   logic ovf_e4;
  logic [22:0] res_f40;  logic vld_f40;  logic ovf_f40;

  fp_custom_from_fixed u_dut_def (
    .Clk_i(clk), .Rst_i(rst), .Data_i(data), .Nd_i(nd),
    .Result_o(res_def), .ResultValid_o(vld_def), .Overflow_o(ovf_def)
  );

  fp_custom_from_fixed #(.ExpWidth(4)) u_dut_e4 (
    .Clk_i(clk), .Rst_i(rst), .Data_i(data), .Nd_i(nd),
    .Result_o(res_e4), .ResultValid_o(vld_e4), .Overflow_o(ovf_e4)
  );

  fp_custom_from_fixed #(.FracWidth(40)) u_dut_f40 (
    .Clk_i(clk), .Rst_i(rst), .Data_i(data), .Nd_i(nd),
    .Result_o(res_f40), .ResultValid_o(vld_f40), .Overflow_o(ovf_f40)
  );

  typedef struct {
    logic signed [15:0] d;
    int                 due;
    bit                 has_def;
    logic [63:0]        lit_def;
    bit                 has_e4;
    logic [63:0]        lit_e4;
    bit                 lit_ovf_e4;
    bit                 has_f40;
    logic [63:0]        lit_f40;
  } pend_t;

  pend_t       q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] last_def = '0, last_e4 = '0, last_f40 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Value-level model: |x| = 2^p * (1.f), e = Bias + p - FracWidth.
  function automatic logic [63:0] ref_conv(input logic signed [15:0] d, input int ew,
                                           input int mw, input int fw, output bit ovf);
    longint v, mag, man;
    int     p, e;
    bit     s;
    v   = longint'(d);
    s   = (v < 0);
    mag = s ? -v : v;
    ovf = 1'b0;
    if (mag == 0) return 64'd0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = (1 << (ew - 1)) - 1 + p - fw;
    if (e <= 0) return 64'd0;
    if (e > (1 << ew) - 1) begin
      ovf = 1'b1;
      return (64'(s) << (ew + mw)) | ((64'd1 << (ew + mw)) - 64'd1);
    end
    man = ((mag << mw) >> p) - (longint'(1) << mw);
    return (64'(s) << (ew + mw)) | (64'(e) << mw) | 64'(man);
  endfunction

  function automatic pend_t mk(input logic signed [15:0] d);
    pend_t p;
    p.d = d; p.due = 0;
    p.has_def = 1'b0; p.lit_def = '0;
    p.has_e4 = 1'b0;  p.lit_e4 = '0; p.lit_ovf_e4 = 1'b0;
    p.has_f40 = 1'b0; p.lit_f40 = '0;
    return p;
  endfunction

  function automatic logic signed [15:0] rand_sample();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return 16'sd0;
      1:       return -16'sd32768;
      2:       return -16'sd1;
      3:       return 16'sd32767;
      default: return r[15:0];
    endcase
  endfunction

  task automatic check_cycle(input bit after_rst);
    bit          ovf;
    logic [63:0] e;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("valid_def", 64'(vld_def), 64'd1);
      chk("valid_e4",  64'(vld_e4),  64'd1);
      chk("valid_f40", 64'(vld_f40), 64'd1);
      e = ref_conv(q[0].d, 6, 16, 0, ovf);
      chk("res_def", 64'(res_def), e);
      chk("ovf_def", 64'(ovf_def), 64'(ovf));
      last_def = e;
      if (q[0].has_def) chk("lit_def", 64'(res_def), q[0].lit_def);
      e = ref_conv(q[0].d, 4, 16, 0, ovf);
      chk("res_e4", 64'(res_e4), e);
      chk("ovf_e4", 64'(ovf_e4), 64'(ovf));
      last_e4 = e;
      if (q[0].has_e4) begin
        chk("lit_e4", 64'(res_e4), q[0].lit_e4);
        chk("lit_ovf_e4", 64'(ovf_e4), 64'(q[0].lit_ovf_e4));
      end
      e = ref_conv(q[0].d, 6, 16, 40, ovf);
      chk("res_f40", 64'(res_f40), e);
      chk("ovf_f40", 64'(ovf_f40), 64'(ovf));
      last_f40 = e;
      if (q[0].has_f40) chk("lit_f40", 64'(res_f40), q[0].lit_f40);
      void'(q.pop_front());
    end else begin
      chk("idle_valid_def", 64'(vld_def), 64'd0);
      chk("idle_valid_e4",  64'(vld_e4),  64'd0);
      chk("idle_valid_f40", 64'(vld_f40), 64'd0);
      chk("hold_def", 64'(res_def), last_def);
      chk("hold_e4",  64'(res_e4),  last_e4);
      chk("hold_f40", 64'(res_f40), last_f40);
    end
    if (after_rst) begin
      chk("rst_ovf_def", 64'(ovf_def), 64'd0);
      chk("rst_ovf_e4",  64'(ovf_e4),  64'd0);
      chk("rst_ovf_f40", 64'(ovf_f40), 64'd0);
    end
  endtask

  // Drive one cycle from a falling edge, account for what the next rising
  // edge accepts, then check on the following falling edge.
  task automatic step(input logic r, input logic n, input pend_t p);
    rst  = r;
    nd   = n;
    data = p.d;
    if (r) begin
      q.delete();
      last_def = '0; last_e4 = '0; last_f40 = '0;
    end else if (n) begin
      p.due = cyc + 1 + FP_LATENCY;
      q.push_back(p);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle(r);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, mk(rand_sample()));
  endtask

  initial begin
    pend_t p;
    rst = 1'b1; nd = 1'b0; data = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mk(16'sd0));

    // Directed values with known encodings, back to back
    p = mk(16'sd1);      p.has_def = 1; p.lit_def = 64'h1F0000; p.has_f40 = 1; p.lit_f40 = 64'h0;
    step(1'b0, 1'b1, p);
    p = mk(-16'sd1);     p.has_def = 1; p.lit_def = 64'h5F0000; step(1'b0, 1'b1, p);
    p = mk(16'sd3);      p.has_def = 1; p.lit_def = 64'h208000; step(1'b0, 1'b1, p);
    p = mk(16'sd0);      p.has_def = 1; p.lit_def = 64'h000000; step(1'b0, 1'b1, p);
    p = mk(-16'sd32768); p.has_def = 1; p.lit_def = 64'h6E0000; step(1'b0, 1'b1, p);
    p = mk(16'sh4000);   p.has_e4 = 1;  p.lit_e4 = 64'h0FFFFF; p.lit_ovf_e4 = 1'b1;
    step(1'b0, 1'b1, p);
    idle(6);

    // Eight consecutive random samples
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, mk(rand_sample()));
    idle(6);

    // Random gaps
    for (int i = 0; i < 150; i++) step(1'b0, ($urandom_range(0, 2) != 0), mk(rand_sample()));
    idle(6);

    // Reset while three samples are in flight; Nd_i during reset is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(rand_sample()));
    step(1'b1, 1'b1, mk(16'sd5));
    p = mk(16'sd3); p.has_def = 1; p.lit_def = 64'h208000;
    step(1'b0, 1'b1, p);
    idle(8);

    chk("drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
